sbc_seq: RTL and testbench
==========================

Name: sbc_seq

Overview:
- Multi-cycle add/subtract-with-carry sequencer.
- Time-multiplexes one DIGIT-bit full-adder/carry slice across a WIDTH-bit operand pair, LSB digit first, carrying between digits in a register.
- Gives the fabric a WIDTH-bit ADC/SBC at the cost of one shared slice.
- Sits between a requester (valid/ready) and the consumer of the result.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT, and WIDTH/DIGIT >= 2.
- DIGIT, 2, bits processed per cycle by the shared slice.

Ports:
- CLKIN input 1 system clock, rising edge.
- RESETN input 1 reset; asynchronous, active-low.
- IN_VALID input 1 request present.
- IN_READY output 1 sequencer can accept a request.
- OP input 1 0 = ADD (A+B+CIN), 1 = SUB (A+~B+CIN).
- A input WIDTH first operand.
- B input WIDTH second operand.
- CIN input 1 carry-in to digit 0 (SUB with CIN=1 is plain A-B).
- OUT_VALID output 1 result available.
- OUT_READY input 1 consumer accepts result.
- D output WIDTH result.
- COUT output 1 carry-out of top digit (SUB: 1 = no borrow).

Behaviour:
- Reset (RESETN low, async): state IDLE; IN_READY=1, OUT_VALID=0, D=0, COUT=0; carry and digit counter cleared.
- Reset release is synchronous to CLKIN; the first request can be accepted on the first edge after release.
- Reset asserted mid-operation aborts immediately; the operation is lost, with no partial result and no OUT_VALID.
- States:
  - IDLE: IN_READY=1. On IN_VALID&IN_READY, latch A, B, OP and CIN; carry<=CIN; idx<=0; go RUN.
  - RUN: IN_READY=0. Each cycle, the slice computes digit idx from A, B^{DIGIT{OP}} and carry, writes it to D[idx*DIGIT +: DIGIT], and updates carry<=slice COUT; idx increments. After digit N-1 (N=WIDTH/DIGIT), go DONE.
  - DONE: OUT_VALID=1; D and COUT=carry held stable. On OUT_READY, go IDLE.
- OUT_VALID is never dropped without OUT_READY; D and COUT do not change while OUT_VALID=1.
- Latency: accept edge at T. Digits are computed on edges T+1..T+N. OUT_VALID is high from the edge at T+N onward. With OUT_READY already high, the result handshakes at T+N+1.
- Throughput: one op per N+2 cycles with OUT_READY held high.
- No request pipelining: IN_READY is high only in IDLE. A request can be accepted on the same edge the result leaves DONE only if the design returns to IDLE first, so back-to-back accept-after-output costs one IDLE cycle.
- Arithmetic is modulo 2^WIDTH; COUT is the true carry out of bit WIDTH-1.
- Operand registers are not modified by the caller after acceptance; changes on A/B/OP/CIN during RUN have no effect.
- OUT_READY high in IDLE/RUN is ignored. IN_VALID high outside IDLE is ignored (not acknowledged).

Decomposition:
- Shared include holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - op codes OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, sbc_slice: DIGIT-bit ripple adder, per bit a 3-input XOR LUT plus SB_CARRY chain, with inputs I0, I1, CIN and outputs O, COUT.
- Operand inversion for SUB is done in sbc_seq before the slice.

Test Plan:
- Reset: hold RESETN low 3 cycles with random inputs -> IN_READY=1, OUT_VALID=0, D=0x00, COUT=0.
- SUB 0x5A-0x23, CIN=1, OUT_READY=1 -> OUT_VALID exactly 4 cycles after accept, D=0x37, COUT=1; IN_READY low for 5 cycles total.
- Borrow wrap: SUB 0x00-0x01, CIN=1 -> D=0xFF, COUT=0. ADD 0x7F+0x80, CIN=1 -> D=0x00, COUT=1 (carry crosses every digit).
- Backpressure: OUT_READY low 6 cycles after OUT_VALID while A/B toggle -> D/COUT stable, IN_READY=0; result leaves on the first OUT_READY edge, then IDLE.
- Mid-op reset: pulse RESETN low during RUN idx=2 -> outputs return to reset values asynchronously. A following SUB 0x10-0x01, CIN=1 gives D=0x0F, COUT=1.
- Random: 1000 ops, mixed OP/CIN and random stalls -> {COUT,D} matches the model A + (OP?~B:B) + CIN in WIDTH+1 bits.

Source files
------------

// File: rtl/sbc_seq_pkg.sv
// Shared definitions for the digit-serial add/subtract-with-carry sequencer.
package sbc_seq_pkg;

    // Sequencer states; encoding is fixed so debug probes can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operation codes on the OP input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sbc_seq_slice.sv
// DIGIT-bit ripple adder slice: per bit a 3-input XOR for the sum and a
// carry cell computing majority(I0, I1, CI), chained LSB to MSB.
module sbc_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] I0,
    input  logic [DIGIT-1:0] I1,
    input  logic             CIN,
    output logic [DIGIT-1:0] O,
    output logic             COUT
);

    logic [DIGIT:0] c;

    assign c[0] = CIN;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign O[i]   = I0[i] ^ I1[i] ^ c[i];
        assign c[i+1] = (I0[i] & I1[i]) | (c[i] & (I0[i] | I1[i]));
    end

    assign COUT = c[DIGIT];

endmodule

// File: rtl/sbc_seq.sv
// Multi-cycle ADC/SBC sequencer: one shared DIGIT-bit slice is stepped across
// a WIDTH-bit operand pair, LSB digit first, with the inter-digit carry held
// in a register. Request and result sides use valid/ready handshakes.
module sbc_seq
    import sbc_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             CLKIN,
    input  logic             RESETN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             COUT
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = $clog2(N);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, d_q;
    logic             op_q;
    logic             carry;
    logic             cout_q;
    logic [IW-1:0]    idx;

    logic             accept;
    logic             step;
    logic             last;

    logic [DIGIT-1:0] a_dig, b_dig, sum;
    logic             slice_cout;

    // Digit operands for the current step; SUB inverts B ahead of the slice.
    assign last  = (idx == IW'(N - 1));
    assign a_dig = a_q[int'(idx) * DIGIT +: DIGIT];
    assign b_dig = (op_q == OP_SUB) ? ~b_q[int'(idx) * DIGIT +: DIGIT]
                                    :  b_q[int'(idx) * DIGIT +: DIGIT];

    sbc_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .I0   (a_dig),
        .I1   (b_dig),
        .CIN  (carry),
        .O    (sum),
        .COUT (slice_cout)
    );

    // State register.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nx  = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    accept   = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand capture, per-digit result write-back and carry propagation.
    // The result registers only change in RUN, so they hold through DONE.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
            carry  <= 1'b0;
            idx    <= '0;
            d_q    <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= OP;
            carry <= CIN;
            idx   <= '0;
        end else if (step) begin
            d_q[int'(idx) * DIGIT +: DIGIT] <= sum;
            carry <= slice_cout;
            if (last) cout_q <= slice_cout;
            else      idx    <= idx + IW'(1);
        end
    end

    assign D    = d_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_sbc_seq.sv
// Self-checking bench for sbc_seq: directed scenarios plus randomized ops
// against an arithmetic reference model.
module tb_sbc_seq;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

    logic             CLKIN = 1'b0;
    logic             RESETN = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic             OP = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             CIN = 1'b0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [WIDTH-1:0] D;
    logic             COUT;

    int n_checks = 0;
    int n_fail   = 0;

    sbc_seq #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .CLKIN     (CLKIN),
        .RESETN    (RESETN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .D         (D),
        .COUT      (COUT)
    );

    always #5 CLKIN = ~CLKIN;

    // Reference: {COUT,D} = A + (OP ? ~B : B) + CIN in WIDTH+1 bits.
    function automatic logic [WIDTH:0] model(input logic op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH-1:0] bb;
        bb = op ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(cin);
    endfunction

    // Drives one request and collects what the DUT did; comparisons are made by callers.
    task automatic run_op(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input int stall,
                          output logic [WIDTH-1:0] d, output logic c, output int lat,
                          output int rdy_low, output bit unstable, output bit exit_ok,
                          output bit timeout);
        int guard;
        d = '0; c = 1'b0; lat = 0; rdy_low = 0; unstable = 1'b0; exit_ok = 1'b0; timeout = 1'b0;
        guard = 0;
        while (!IN_READY && guard < 20) begin
            @(posedge CLKIN); #1; guard++;
        end
        if (!IN_READY) begin
            timeout = 1'b1;
            return;
        end
        OP = op; A = a; B = b; CIN = cin; IN_VALID = 1'b1;
        OUT_READY = (stall == 0);
        @(posedge CLKIN); #1;
        if (!IN_READY) rdy_low++;
        while (!OUT_VALID && lat < 50) begin
            // inputs during RUN must be ignored
            IN_VALID = 1'($urandom); A = WIDTH'($urandom); B = WIDTH'($urandom);
            OP = 1'($urandom); CIN = 1'($urandom);
            @(posedge CLKIN); #1; lat++;
            if (!IN_READY) rdy_low++;
        end
        IN_VALID = 1'b0;
        if (!OUT_VALID) begin
            timeout = 1'b1;
            return;
        end
        d = D; c = COUT;
        for (int i = 0; i < stall; i++) begin
            A = WIDTH'($urandom); B = WIDTH'($urandom);
            @(posedge CLKIN); #1;
            if (D !== d || COUT !== c || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) unstable = 1'b1;
        end
        OUT_READY = 1'b1;
        @(posedge CLKIN); #1;
        exit_ok = (OUT_VALID === 1'b0) && (IN_READY === 1'b1);
        OUT_READY = 1'($urandom);
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLKIN); #1;
            IN_VALID = 1'($urandom); OUT_READY = 1'($urandom); OP = 1'($urandom);
            A = WIDTH'($urandom); B = WIDTH'($urandom); CIN = 1'($urandom);
        end
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
        n_checks++; if (D !== 8'h00) begin n_fail++; $display("FAIL reset_d: got %h expected 00", D); end
        n_checks++; if (COUT !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", COUT); end
        IN_VALID = 1'b0;
        RESETN = 1'b1;
    endtask

    task automatic test_sub_basic();
        logic [WIDTH-1:0] d; logic c; int lat, rl; bit us, ex, to;
        run_op(1'b1, 8'h5A, 8'h23, 1'b1, 0, d, c, lat, rl, us, ex, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL sub_timeout: no result within bound"); end
        n_checks++; if (d !== 8'h37) begin n_fail++; $display("FAIL sub_d: got %h expected 37", d); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL sub_cout: got %b expected 1", c); end
        n_checks++; if (lat != N) begin n_fail++; $display("FAIL sub_latency: got %0d expected %0d", lat, N); end
        n_checks++; if (rl != N + 1) begin n_fail++; $display("FAIL sub_in_ready_low: got %0d expected %0d", rl, N + 1); end
        n_checks++; if (!ex) begin n_fail++; $display("FAIL sub_exit: result did not leave to IDLE"); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] d; logic c; int lat, rl; bit us, ex, to;
        run_op(1'b1, 8'h00, 8'h01, 1'b1, 0, d, c, lat, rl, us, ex, to);
        n_checks++; if (to || d !== 8'hFF) begin n_fail++; $display("FAIL borrow_d: got %h expected ff", d); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL borrow_cout: got %b expected 0", c); end
        run_op(1'b0, 8'h7F, 8'h80, 1'b1, 0, d, c, lat, rl, us, ex, to);
        n_checks++; if (to || d !== 8'h00) begin n_fail++; $display("FAIL carry_d: got %h expected 00", d); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL carry_cout: got %b expected 1", c); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d; logic c; int lat, rl; bit us, ex, to;
        run_op(1'b0, 8'h3C, 8'h4B, 1'b0, 6, d, c, lat, rl, us, ex, to);
        n_checks++; if (to || d !== 8'h87) begin n_fail++; $display("FAIL bp_d: got %h expected 87", d); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL bp_cout: got %b expected 0", c); end
        n_checks++; if (us) begin n_fail++; $display("FAIL bp_stable: outputs changed while stalled"); end
        n_checks++; if (!ex) begin n_fail++; $display("FAIL bp_exit: result did not leave on first OUT_READY edge"); end
    endtask

    task automatic test_midop_reset();
        logic [WIDTH-1:0] d; logic c; int lat, rl; bit us, ex, to;
        bit saw_valid;
        int guard;
        guard = 0;
        while (!IN_READY && guard < 20) begin @(posedge CLKIN); #1; guard++; end
        OP = 1'b0; A = 8'hFF; B = 8'hFF; CIN = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(posedge CLKIN); #1;   // accepted
        IN_VALID = 1'b0;
        @(posedge CLKIN);       // digit 0
        @(posedge CLKIN); #1;   // digit 1 done, idx = 2
        RESETN = 1'b0;
        #1;
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 1", IN_READY); end
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b expected 0", OUT_VALID); end
        n_checks++; if (D !== 8'h00) begin n_fail++; $display("FAIL mid_rst_d: got %h expected 00", D); end
        n_checks++; if (COUT !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cout: got %b expected 0", COUT); end
        #2 RESETN = 1'b1;
        OUT_READY = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLKIN); #1;
            if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) saw_valid = 1'b1;
        end
        n_checks++; if (saw_valid) begin n_fail++; $display("FAIL mid_rst_no_result: aborted op produced activity"); end
        run_op(1'b1, 8'h10, 8'h01, 1'b1, 0, d, c, lat, rl, us, ex, to);
        n_checks++; if (to || d !== 8'h0F) begin n_fail++; $display("FAIL post_rst_d: got %h expected 0f", d); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL post_rst_cout: got %b expected 1", c); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d, a, b; logic c, op, cin; int lat, rl; bit us, ex, to;
        logic [WIDTH:0] exp;
        for (int k = 0; k < 1000; k++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            op = 1'($urandom); cin = 1'($urandom);
            exp = model(op, a, b, cin);
            run_op(op, a, b, cin, int'($urandom_range(0, 3)), d, c, lat, rl, us, ex, to);
            n_checks++;
            if (to || {c, d} !== exp) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: op=%b a=%h b=%h cin=%b got %b_%h expected %b_%h",
                         k, op, a, b, cin, c, d, exp[WIDTH], exp[WIDTH-1:0]);
            end
            n_checks++;
            if (lat != N || us || !ex) begin
                n_fail++;
                $display("FAIL rand_handshake[%0d]: latency %0d expected %0d unstable=%b exit=%b",
                         k, lat, N, us, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub_basic();
        test_wrap();
        test_backpressure();
        test_midop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
